// File: rtl/vscale_hasti_arbiter_pkg.sv
// Shared HASTI (AHB-Lite) constants, owner encodings and the buffered
// address-phase record used by the two-master arbiter.
package vscale_hasti_arbiter_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;

  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'b00;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'b01;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'b10;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'b11;

  localparam logic HASTI_RESP_OKAY  = 1'b0;
  localparam logic HASTI_RESP_ERROR = 1'b1;

  // Which master owns the slave data phase.
  typedef enum logic [1:0] {
    HASTI_MASTER_NONE = 2'd0,
    HASTI_MASTER_IMEM = 2'd1,
    HASTI_MASTER_DMEM = 2'd2
  } hasti_master_e;

  // Address-phase fields that must be preserved when a request is buffered.
  typedef struct packed {
    logic [HASTI_ADDR_WIDTH-1:0]  haddr;
    logic                         hwrite;
    logic [HASTI_SIZE_WIDTH-1:0]  hsize;
    logic [HASTI_BURST_WIDTH-1:0] hburst;
    logic [HASTI_PROT_WIDTH-1:0]  hprot;
    logic                         hmastlock;
  } hasti_aphase_t;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic hasti_trans_active(input logic [HASTI_TRANS_WIDTH-1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/vscale_hasti_arbiter_if.sv
// One HASTI port: request signals flow master->slave, response slave->master.
interface vscale_hasti_arbiter_if;
  import vscale_hasti_arbiter_pkg::*;

  logic [HASTI_ADDR_WIDTH-1:0]  haddr;
  logic                         hwrite;
  logic [HASTI_SIZE_WIDTH-1:0]  hsize;
  logic [HASTI_BURST_WIDTH-1:0] hburst;
  logic                         hmastlock;
  logic [HASTI_PROT_WIDTH-1:0]  hprot;
  logic [HASTI_TRANS_WIDTH-1:0] htrans;
  logic [HASTI_BUS_WIDTH-1:0]   hwdata;
  logic [HASTI_BUS_WIDTH-1:0]   hrdata;
  logic                         hready;
  logic                         hresp;

  modport master (
    output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/vscale_hasti_arbiter_req_buf.sv
// Per-master input stage: holds one address phase that could not be issued
// in the cycle the master presented it, and offers either that buffered
// phase or the live one to the arbiter.
module vscale_hasti_req_buf
  import vscale_hasti_arbiter_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         hready_i,
  input  logic [HASTI_TRANS_WIDTH-1:0] htrans_i,
  input  hasti_aphase_t                aphase_i,
  input  logic                         grant_i,
  output logic                         req_o,
  output logic                         pend_valid_o,
  output hasti_aphase_t                aphase_o
);

  logic          pend_valid_q, pend_valid_d;
  hasti_aphase_t buf_q, buf_d;
  logic          live_s;

  // The master only believes its address was taken when it sees hready high.
  assign live_s       = hready_i & hasti_trans_active(htrans_i);
  assign req_o        = pend_valid_q | live_s;
  assign pend_valid_o = pend_valid_q;
  assign aphase_o     = pend_valid_q ? buf_q : aphase_i;

  // Capture a live phase that was not issued; a grant consumes the buffer.
  always_comb begin
    pend_valid_d = pend_valid_q;
    buf_d        = buf_q;
    if (live_s && !grant_i) begin
      pend_valid_d = 1'b1;
      buf_d        = aphase_i;
    end else if (grant_i) begin
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // Buffer state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      buf_q        <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      buf_q        <= buf_d;
    end
  end

endmodule

// File: rtl/vscale_hasti_arbiter.sv
// Two-master (imem, dmem) to one-slave HASTI arbiter. An uncontended live
// request passes straight through; a losing or stalled request is buffered
// and issued later. Data-phase ownership steers hwdata and hresp.
module vscale_hasti_arbiter
  import vscale_hasti_arbiter_pkg::*;
#(
  parameter int DMEM_PRIORITY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  vscale_hasti_arbiter_if.slave   imem,
  vscale_hasti_arbiter_if.slave   dmem,
  vscale_hasti_arbiter_if.master  mem
);

  localparam bit  DMEM_WINS_TIES = (DMEM_PRIORITY != 32'sd0);
  localparam logic LAST_IMEM = 1'b0;
  localparam logic LAST_DMEM = 1'b1;

  hasti_master_e dph_owner_q, dph_owner_d;
  logic          last_grant_q, last_grant_d;
  hasti_aphase_t hold_aphase_q;
  logic [HASTI_TRANS_WIDTH-1:0] hold_trans_q;

  hasti_aphase_t imem_live_s, dmem_live_s, imem_sel_s, dmem_sel_s, out_aphase_s;
  logic [HASTI_TRANS_WIDTH-1:0] out_trans_s;
  logic imem_req_s, dmem_req_s, imem_pend_s, dmem_pend_s;
  logic imem_hready_s, dmem_hready_s, grant_imem_s, grant_dmem_s;

  assign imem_live_s = '{haddr: imem.haddr, hwrite: imem.hwrite, hsize: imem.hsize,
                         hburst: imem.hburst, hprot: imem.hprot, hmastlock: imem.hmastlock};
  assign dmem_live_s = '{haddr: dmem.haddr, hwrite: dmem.hwrite, hsize: dmem.hsize,
                         hburst: dmem.hburst, hprot: dmem.hprot, hmastlock: dmem.hmastlock};

  // The owner waits on the slave; anyone else is stalled only by its own buffer.
  assign imem_hready_s = (dph_owner_q == HASTI_MASTER_IMEM) ? mem.hready : !imem_pend_s;
  assign dmem_hready_s = (dph_owner_q == HASTI_MASTER_DMEM) ? mem.hready : !dmem_pend_s;

  vscale_hasti_req_buf u_imem_buf (
    .clk          (clk),
    .reset        (reset),
    .hready_i     (imem_hready_s),
    .htrans_i     (imem.htrans),
    .aphase_i     (imem_live_s),
    .grant_i      (grant_imem_s),
    .req_o        (imem_req_s),
    .pend_valid_o (imem_pend_s),
    .aphase_o     (imem_sel_s)
  );

  vscale_hasti_req_buf u_dmem_buf (
    .clk          (clk),
    .reset        (reset),
    .hready_i     (dmem_hready_s),
    .htrans_i     (dmem.htrans),
    .aphase_i     (dmem_live_s),
    .grant_i      (grant_dmem_s),
    .req_o        (dmem_req_s),
    .pend_valid_o (dmem_pend_s),
    .aphase_o     (dmem_sel_s)
  );

  // Pick a winner only when the slave can accept a new address phase.
  always_comb begin
    grant_imem_s = 1'b0;
    grant_dmem_s = 1'b0;
    if (mem.hready) begin
      if (imem_req_s && dmem_req_s) begin
        if (DMEM_WINS_TIES || (last_grant_q == LAST_IMEM)) begin
          grant_dmem_s = 1'b1;
        end else begin
          grant_imem_s = 1'b1;
        end
      end else if (dmem_req_s) begin
        grant_dmem_s = 1'b1;
      end else if (imem_req_s) begin
        grant_imem_s = 1'b1;
      end else begin
        grant_imem_s = 1'b0;
      end
    end else begin
      grant_dmem_s = 1'b0;
    end
  end

  // Slave address mux; during slave wait states the last driven phase is held.
  always_comb begin
    out_aphase_s = hold_aphase_q;
    out_trans_s  = hold_trans_q;
    if (mem.hready) begin
      if (grant_dmem_s) begin
        out_aphase_s = dmem_sel_s;
        out_trans_s  = HASTI_TRANS_NONSEQ;
      end else if (grant_imem_s) begin
        out_aphase_s = imem_sel_s;
        out_trans_s  = HASTI_TRANS_NONSEQ;
      end else begin
        out_aphase_s = '0;
        out_trans_s  = HASTI_TRANS_IDLE;
      end
    end else begin
      out_trans_s = hold_trans_q;
    end
  end

  // Data-phase owner and round-robin history advance only on accepted cycles.
  always_comb begin
    dph_owner_d  = dph_owner_q;
    last_grant_d = last_grant_q;
    if (mem.hready) begin
      if (grant_dmem_s) begin
        dph_owner_d  = HASTI_MASTER_DMEM;
        last_grant_d = LAST_DMEM;
      end else if (grant_imem_s) begin
        dph_owner_d  = HASTI_MASTER_IMEM;
        last_grant_d = LAST_IMEM;
      end else begin
        dph_owner_d  = HASTI_MASTER_NONE;
      end
    end else begin
      dph_owner_d = dph_owner_q;
    end
  end

  // Owner, grant history and held address phase registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dph_owner_q   <= HASTI_MASTER_NONE;
      last_grant_q  <= LAST_IMEM;
      hold_aphase_q <= '0;
      hold_trans_q  <= HASTI_TRANS_IDLE;
    end else begin
      dph_owner_q   <= dph_owner_d;
      last_grant_q  <= last_grant_d;
      hold_aphase_q <= out_aphase_s;
      hold_trans_q  <= out_trans_s;
    end
  end

  assign mem.haddr     = out_aphase_s.haddr;
  assign mem.hwrite    = out_aphase_s.hwrite;
  assign mem.hsize     = out_aphase_s.hsize;
  assign mem.hburst    = out_aphase_s.hburst;
  assign mem.hprot     = out_aphase_s.hprot;
  assign mem.hmastlock = out_aphase_s.hmastlock;
  assign mem.htrans    = out_trans_s;

  // Write data follows whichever master owns the current data phase.
  always_comb begin
    mem.hwdata = '0;
    case (dph_owner_q)
      HASTI_MASTER_IMEM: mem.hwdata = imem.hwdata;
      HASTI_MASTER_DMEM: mem.hwdata = dmem.hwdata;
      default:           mem.hwdata = '0;
    endcase
  end

  assign imem.hrdata = mem.hrdata;
  assign dmem.hrdata = mem.hrdata;
  assign imem.hready = imem_hready_s;
  assign dmem.hready = dmem_hready_s;
  assign imem.hresp  = (dph_owner_q == HASTI_MASTER_IMEM) ? mem.hresp : HASTI_RESP_OKAY;
  assign dmem.hresp  = (dph_owner_q == HASTI_MASTER_DMEM) ? mem.hresp : HASTI_RESP_OKAY;

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Directed bench for the two-master HASTI arbiter: a fixed-priority instance
// and a round-robin instance, with a scoreboard of expected slave issues.
module tb_vscale_hasti_arbiter;
  import vscale_hasti_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vscale_hasti_arbiter_if p_imem ();
  vscale_hasti_arbiter_if p_dmem ();
  vscale_hasti_arbiter_if p_mem ();
  vscale_hasti_arbiter_if r_imem ();
  vscale_hasti_arbiter_if r_dmem ();
  vscale_hasti_arbiter_if r_mem ();

  vscale_hasti_arbiter #(.DMEM_PRIORITY(1)) dut_p (
    .clk(clk), .reset(reset), .imem(p_imem), .dmem(p_dmem), .mem(p_mem));
  vscale_hasti_arbiter #(.DMEM_PRIORITY(0)) dut_r (
    .clk(clk), .reset(reset), .imem(r_imem), .dmem(r_dmem), .mem(r_mem));

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
  } exp_t;

  exp_t q_p[$];
  exp_t q_r[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic p_imem_drv(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [31:0] wd);
    p_imem.htrans = t; p_imem.haddr = a; p_imem.hwrite = w; p_imem.hwdata = wd;
  endtask
  task automatic p_dmem_drv(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [31:0] wd);
    p_dmem.htrans = t; p_dmem.haddr = a; p_dmem.hwrite = w; p_dmem.hwdata = wd;
  endtask
  task automatic r_imem_drv(input logic [1:0] t, input logic [31:0] a);
    r_imem.htrans = t; r_imem.haddr = a; r_imem.hwrite = 1'b0; r_imem.hwdata = 32'h0;
  endtask
  task automatic r_dmem_drv(input logic [1:0] t, input logic [31:0] a);
    r_dmem.htrans = t; r_dmem.haddr = a; r_dmem.hwrite = 1'b0; r_dmem.hwdata = 32'h0;
  endtask

  // Scoreboard pop for the fixed-priority instance on every accepted issue.
  always @(negedge clk) begin
    if (p_mem.hready && p_mem.htrans == HASTI_TRANS_NONSEQ) begin
      exp_t e;
      n_assert++;
      assert (q_p.size() > 0) else begin
        n_fail++;
        $error("FAIL p_sb_unexpected: observed issue of %08h expected none", p_mem.haddr);
      end
      if (q_p.size() > 0) begin
        e = q_p.pop_front();
        chk("p_sb_addr", p_mem.haddr, e.addr);
        chk("p_sb_write", {31'd0, p_mem.hwrite}, {31'd0, e.write});
      end
    end
  end

  // Scoreboard pop for the round-robin instance.
  always @(negedge clk) begin
    if (r_mem.hready && r_mem.htrans == HASTI_TRANS_NONSEQ) begin
      exp_t e;
      n_assert++;
      assert (q_r.size() > 0) else begin
        n_fail++;
        $error("FAIL r_sb_unexpected: observed issue of %08h expected none", r_mem.haddr);
      end
      if (q_r.size() > 0) begin
        e = q_r.pop_front();
        chk("r_sb_addr", r_mem.haddr, e.addr);
      end
    end
  end

  initial begin
    logic [31:0] ia;
    logic [31:0] da;
    reset = 1'b1;
    p_imem_drv(HASTI_TRANS_IDLE, 32'h0, 1'b0, 32'h0);
    p_dmem_drv(HASTI_TRANS_IDLE, 32'h0, 1'b0, 32'h0);
    r_imem_drv(HASTI_TRANS_IDLE, 32'h0);
    r_dmem_drv(HASTI_TRANS_IDLE, 32'h0);
    p_imem.hsize = 3'd2; p_imem.hburst = 3'd0; p_imem.hprot = 4'd3; p_imem.hmastlock = 1'b0;
    p_dmem.hsize = 3'd2; p_dmem.hburst = 3'd0; p_dmem.hprot = 4'd3; p_dmem.hmastlock = 1'b0;
    r_imem.hsize = 3'd2; r_imem.hburst = 3'd0; r_imem.hprot = 4'd3; r_imem.hmastlock = 1'b0;
    r_dmem.hsize = 3'd2; r_dmem.hburst = 3'd0; r_dmem.hprot = 4'd3; r_dmem.hmastlock = 1'b0;
    p_mem.hready = 1'b1; p_mem.hrdata = 32'h0; p_mem.hresp = 1'b0;
    r_mem.hready = 1'b1; r_mem.hrdata = 32'h0; r_mem.hresp = 1'b0;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_htrans", {30'd0, p_mem.htrans}, {30'd0, HASTI_TRANS_IDLE});
    chk("rst_haddr", p_mem.haddr, 32'h0);
    chk("rst_imem_hready", {31'd0, p_imem.hready}, 32'd1);
    chk("rst_dmem_hready", {31'd0, p_dmem.hready}, 32'd1);
    chk("rst_hresp", {30'd0, p_imem.hresp, p_dmem.hresp}, 32'd0);

    // Idle bus: imem read passes straight through.
    step();
    p_imem_drv(HASTI_TRANS_NONSEQ, 32'h100, 1'b0, 32'h0);
    q_p.push_back('{addr: 32'h100, write: 1'b0});
    @(negedge clk);
    chk("t1_haddr", p_mem.haddr, 32'h100);
    chk("t1_htrans", {30'd0, p_mem.htrans}, {30'd0, HASTI_TRANS_NONSEQ});
    chk("t1_imem_hready", {31'd0, p_imem.hready}, 32'd1);
    step();
    p_imem_drv(HASTI_TRANS_IDLE, 32'h0, 1'b0, 32'h0);
    p_mem.hready = 1'b0;
    @(negedge clk);
    chk("t1_wait_hready", {31'd0, p_imem.hready}, 32'd0);
    chk("t1_hold_haddr", p_mem.haddr, 32'h100);
    step();
    p_mem.hready = 1'b1; p_mem.hrdata = 32'hCAFE0100;
    @(negedge clk);
    chk("t1_done_hready", {31'd0, p_imem.hready}, 32'd1);
    chk("t1_hrdata", p_imem.hrdata, 32'hCAFE0100);
    chk("t1_idle_htrans", {30'd0, p_mem.htrans}, {30'd0, HASTI_TRANS_IDLE});

    // Contention with dmem priority: dmem first, imem buffered then issued.
    step();
    p_imem_drv(HASTI_TRANS_NONSEQ, 32'h200, 1'b0, 32'h0);
    p_dmem_drv(HASTI_TRANS_NONSEQ, 32'h300, 1'b1, 32'h0);
    q_p.push_back('{addr: 32'h300, write: 1'b1});
    q_p.push_back('{addr: 32'h200, write: 1'b0});
    @(negedge clk);
    chk("t2_first_haddr", p_mem.haddr, 32'h300);
    chk("t2_first_imem_hready", {31'd0, p_imem.hready}, 32'd1);
    step();
    p_imem_drv(HASTI_TRANS_IDLE, 32'h0, 1'b0, 32'h0);
    p_dmem_drv(HASTI_TRANS_IDLE, 32'h0, 1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("t2_second_haddr", p_mem.haddr, 32'h200);
    chk("t2_hwdata", p_mem.hwdata, 32'hDEADBEEF);
    chk("t2_buf_imem_hready", {31'd0, p_imem.hready}, 32'd0);
    chk("t2_dmem_hready", {31'd0, p_dmem.hready}, 32'd1);
    step();
    p_dmem_drv(HASTI_TRANS_IDLE, 32'h0, 1'b0, 32'h0);
    p_mem.hready = 1'b0;
    @(negedge clk);
    chk("t2_imem_wait", {31'd0, p_imem.hready}, 32'd0);
    chk("t2_imem_hwdata", p_mem.hwdata, 32'h0);
    step();
    p_mem.hready = 1'b1; p_mem.hrdata = 32'h12345678;
    @(negedge clk);
    chk("t2_imem_done", {31'd0, p_imem.hready}, 32'd1);
    chk("t2_hrdata", p_imem.hrdata, 32'h12345678);

    // Non-owner request during 3 slave wait states.
    step();
    p_dmem_drv(HASTI_TRANS_NONSEQ, 32'h400, 1'b0, 32'h0);
    q_p.push_back('{addr: 32'h400, write: 1'b0});
    @(negedge clk);
    chk("t3_dmem_haddr", p_mem.haddr, 32'h400);
    step();
    p_dmem_drv(HASTI_TRANS_IDLE, 32'h0, 1'b0, 32'h0);
    p_imem_drv(HASTI_TRANS_NONSEQ, 32'h500, 1'b0, 32'h0);
    q_p.push_back('{addr: 32'h500, write: 1'b0});
    p_mem.hready = 1'b0;
    @(negedge clk);
    chk("t3_capture_hready", {31'd0, p_imem.hready}, 32'd1);
    chk("t3_dmem_wait", {31'd0, p_dmem.hready}, 32'd0);
    chk("t3_hold_haddr_w1", p_mem.haddr, 32'h400);
    for (int w = 2; w <= 3; w++) begin
      step();
      p_imem_drv(HASTI_TRANS_IDLE, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      chk("t3_pend_hready", {31'd0, p_imem.hready}, 32'd0);
      chk("t3_hold_haddr", p_mem.haddr, 32'h400);
      chk("t3_hold_htrans", {30'd0, p_mem.htrans}, {30'd0, HASTI_TRANS_NONSEQ});
    end
    step();
    p_mem.hready = 1'b1;
    @(negedge clk);
    chk("t3_buf_issue_haddr", p_mem.haddr, 32'h500);
    chk("t3_dmem_done", {31'd0, p_dmem.hready}, 32'd1);
    step();
    @(negedge clk);
    chk("t3_imem_done", {31'd0, p_imem.hready}, 32'd1);

    // Two-cycle ERROR on a dmem write, with imem buffered behind it.
    step();
    p_dmem_drv(HASTI_TRANS_NONSEQ, 32'h600, 1'b1, 32'h0);
    q_p.push_back('{addr: 32'h600, write: 1'b1});
    @(negedge clk);
    step();
    p_dmem_drv(HASTI_TRANS_IDLE, 32'h0, 1'b0, 32'h0000600D);
    p_imem_drv(HASTI_TRANS_NONSEQ, 32'h700, 1'b0, 32'h0);
    q_p.push_back('{addr: 32'h700, write: 1'b0});
    p_mem.hready = 1'b0; p_mem.hresp = 1'b1;
    @(negedge clk);
    chk("t5_err1_dmem_hresp", {31'd0, p_dmem.hresp}, 32'd1);
    chk("t5_err1_imem_hresp", {31'd0, p_imem.hresp}, 32'd0);
    chk("t5_err1_dmem_hready", {31'd0, p_dmem.hready}, 32'd0);
    step();
    p_imem_drv(HASTI_TRANS_IDLE, 32'h0, 1'b0, 32'h0);
    p_mem.hready = 1'b1;
    @(negedge clk);
    chk("t5_err2_dmem_hresp", {31'd0, p_dmem.hresp}, 32'd1);
    chk("t5_err2_imem_hresp", {31'd0, p_imem.hresp}, 32'd0);
    chk("t5_followon_haddr", p_mem.haddr, 32'h700);
    step();
    p_dmem_drv(HASTI_TRANS_IDLE, 32'h0, 1'b0, 32'h0);
    p_mem.hresp = 1'b0;
    @(negedge clk);
    chk("t5_after_hresp", {30'd0, p_imem.hresp, p_dmem.hresp}, 32'd0);
    chk("t5_after_imem_hready", {31'd0, p_imem.hready}, 32'd1);

    // Both buffers filled while the slave stalls, then reset mid-transfer.
    step();
    p_imem_drv(HASTI_TRANS_NONSEQ, 32'h800, 1'b0, 32'h0);
    p_dmem_drv(HASTI_TRANS_NONSEQ, 32'h900, 1'b1, 32'h0);
    p_mem.hready = 1'b0;
    @(negedge clk);
    chk("t6_both_accept", {30'd0, p_imem.hready, p_dmem.hready}, 32'd3);
    step();
    p_imem_drv(HASTI_TRANS_IDLE, 32'h0, 1'b0, 32'h0);
    p_dmem_drv(HASTI_TRANS_IDLE, 32'h0, 1'b0, 32'h0);
    p_mem.hready = 1'b1;
    reset = 1'b1;
    q_p.push_back('{addr: 32'h900, write: 1'b1});
    @(negedge clk);
    chk("t6_both_pend", {30'd0, p_imem.hready, p_dmem.hready}, 32'd0);
    chk("t6_inflight_haddr", p_mem.haddr, 32'h900);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_htrans", {30'd0, p_mem.htrans}, {30'd0, HASTI_TRANS_IDLE});
    chk("t6_rst_haddr", p_mem.haddr, 32'h0);
    chk("t6_rst_hready", {30'd0, p_imem.hready, p_dmem.hready}, 32'd3);
    chk("t6_rst_hresp", {30'd0, p_imem.hresp, p_dmem.hresp}, 32'd0);
    chk("t6_rst_hwdata", p_mem.hwdata, 32'h0);
    step();
    @(negedge clk);
    chk("t6_no_stale_issue", {30'd0, p_mem.htrans}, {30'd0, HASTI_TRANS_IDLE});

    // Round-robin: both masters stream reads; grants must alternate.
    ia = 32'h1000;
    da = 32'h2000;
    for (int k = 0; k <= 8; k++) begin
      step();
      if (k < 8) begin
        r_imem_drv(HASTI_TRANS_NONSEQ, ia);
        r_dmem_drv(HASTI_TRANS_NONSEQ, da);
      end else begin
        r_imem_drv(HASTI_TRANS_IDLE, 32'h0);
        r_dmem_drv(HASTI_TRANS_IDLE, 32'h0);
      end
      if (k % 2 == 0) q_r.push_back('{addr: 32'h2000 + 32'(4 * (k / 2)), write: 1'b0});
      else            q_r.push_back('{addr: 32'h1000 + 32'(4 * (k / 2)), write: 1'b0});
      @(negedge clk);
      chk("rr_imem_hready", {31'd0, r_imem.hready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_dmem_hready", {31'd0, r_dmem.hready}, (k == 0 || k % 2 == 1) ? 32'd1 : 32'd0);
      if (r_imem.hready) ia = ia + 32'd4;
      if (r_dmem.hready) da = da + 32'd4;
    end
    step();
    @(negedge clk);
    chk("rr_idle_htrans", {30'd0, r_mem.htrans}, {30'd0, HASTI_TRANS_IDLE});

    chk("p_sb_drained", 32'(q_p.size()), 32'd0);
    chk("r_sb_drained", 32'(q_r.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
